phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter WIDTH, default 32: width of duration and remaining count.
REQ-002 Parameter PRESCALE, default 1: clk cycles per count decrement; legal range is 1 or greater.
REQ-003 clk  input  1  single clock for all logic; every state change occurs on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load request, sampled each rising edge; level-sensitive, asserted by the phase controller for one cycle.
REQ-006 duration  input  WIDTH  phase length in counts; sampled only on an edge where start=1.
REQ-007 pause  input  1  level; while high, counting holds.
REQ-008 abort  input  1  cancel the running phase without a completion indication.
REQ-009 done  output  1  registered completion pulse, exactly one cycle wide.
REQ-010 busy  output  1  registered; high while in RUN or PAUSED.
REQ-011 remaining  output  WIDTH  registered count still to elapse.

Function
REQ-012 The block SHALL implement states IDLE, RUN and PAUSED.
REQ-013 Input priority on any edge SHALL be reset > abort > start > pause > count.
REQ-014 In any state, start=1 with duration≠0 SHALL load remaining=duration, clear the prescaler and enter RUN; a restart during RUN or PAUSED is legal.
REQ-015 In any state, start=1 with duration=0 SHALL set remaining=0, go to IDLE and assert done on the next cycle.
REQ-016 In RUN, the prescaler SHALL count 0..PRESCALE-1, and remaining SHALL decrement by 1 on the edge where the prescaler wraps.
REQ-017 With PRESCALE=1 and start sampled at edge E, done SHALL be high during the cycle following edge E+N (N=duration), with remaining=0.
REQ-018 When a decrement takes remaining from 1 to 0, the block SHALL enter IDLE and assert done for exactly one cycle.
REQ-019 remaining SHALL never wrap below 0; in IDLE it SHALL hold its last value, which is 0 after completion or abort.
REQ-020 In RUN, pause=1 with no start or abort SHALL enter PAUSED; the prescaler and remaining SHALL freeze.
REQ-021 In PAUSED, pause=0 SHALL return to RUN, resuming the prescaler from its frozen value.
REQ-022 abort=1 in RUN or PAUSED SHALL enter IDLE with remaining=0 and no done pulse; abort in IDLE SHALL have no effect.
REQ-023 If start coincides with the expiry edge, the reload SHALL win and done SHALL NOT pulse.
REQ-024 If pause coincides with the expiry edge, pause SHALL win; expiry SHALL occur after resume.
REQ-025 busy SHALL be 1 exactly when the state is RUN or PAUSED.

Reset
REQ-026 An edge with reset=1 SHALL set state=IDLE, prescaler=0, remaining=0, done=0 and busy=0, regardless of the other inputs.
REQ-027 Reset asserted mid-phase SHALL discard the phase with no done pulse.

Configuration
REQ-028 Macro PHASE_TIMER_PAUSE_EN: when defined, the pause input and the PAUSED state SHALL behave as specified above.
REQ-029 When PHASE_TIMER_PAUSE_EN is undefined, pause SHALL be ignored, PAUSED SHALL be unreachable, and REQ-020, REQ-021 and REQ-024 do not apply.

Verification
REQ-030 PRESCALE=1: reset, then start with duration=5 at edge 0 -> busy=1 and remaining steps 5,4,3,2,1,0; done=1 for one cycle after edge 5, then busy=0.
REQ-031 PRESCALE=4, duration=3 -> done arrives 12 cycles after the start edge; remaining decrements every 4th cycle.
REQ-032 PAUSE_EN defined, duration=10, pause held for 7 cycles starting at remaining=6 -> remaining holds 6, busy stays 1; done arrives 7 cycles later than in an unpaused run.
REQ-033 duration=8, abort at remaining=3 -> next cycle IDLE, remaining=0, busy=0; done never asserts.
REQ-034 Restart at remaining=2 with duration=4 -> remaining=4 and no done pulse; duration=0 start -> done after one cycle and busy stays 0.
REQ-035 Reset asserted at remaining=5 -> all outputs 0 on the next cycle; PAUSE_EN undefined with pause=1 -> timing identical to REQ-030.

Source files
------------

// File: rtl/phase_timer_if.sv
// Phase timer handshake bundle: the phase controller (master) loads and steers the
// timer (slave) and observes completion, occupancy and the count still to elapse.
interface phase_timer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] duration;
  logic             pause;
  logic             abort;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] remaining;

  modport master (
    output start, duration, pause, abort,
    input  done, busy, remaining
  );

  modport slave (
    input  start, duration, pause, abort,
    output done, busy, remaining
  );
endinterface

// File: rtl/phase_timer.sv
// Phase timer: loads a duration, counts it down every PRESCALE clocks, pulses done on expiry.
// Optional pause/PAUSED support is enabled by defining PHASE_TIMER_PAUSE_EN.
module phase_timer #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  phase_timer_if.slave tif
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(PRESCALE - 32'sd1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(32'd1);
  localparam logic [PW-1:0]    PRESC_ZERO = PW'(32'd0);
  localparam logic [WIDTH-1:0] REM_ONE    = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] REM_ZERO   = WIDTH'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e           state_r;
  logic [PW-1:0]    presc_r;
  logic [WIDTH-1:0] remaining_r;
  logic             done_r;
  logic             busy_r;

  logic             hold_s;
  logic             wrap_s;
  logic             expire_s;
  logic [PW-1:0]    presc_next_s;
  logic [WIDTH-1:0] rem_dec_s;

  // Next-count values for an edge on which the timer is allowed to advance.
  always_comb begin
    hold_s       = 1'b0;
    presc_next_s = PRESC_ZERO;
    rem_dec_s    = REM_ZERO;
`ifdef PHASE_TIMER_PAUSE_EN
    hold_s = tif.pause;
`else
    hold_s = 1'b0;
`endif
    wrap_s   = (presc_r == PRESC_MAX);
    // Remaining of 0 while running is treated as already expired so it never wraps.
    expire_s = wrap_s && (remaining_r <= REM_ONE);
    if (wrap_s) begin
      presc_next_s = PRESC_ZERO;
    end else begin
      presc_next_s = presc_r + PRESC_ONE;
    end
    if (remaining_r == REM_ZERO) begin
      rem_dec_s = REM_ZERO;
    end else begin
      rem_dec_s = remaining_r - REM_ONE;
    end
  end

  // Phase state machine with registered done/busy/remaining.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      presc_r     <= PRESC_ZERO;
      remaining_r <= REM_ZERO;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (tif.abort && (state_r != ST_IDLE)) begin
        state_r     <= ST_IDLE;
        presc_r     <= PRESC_ZERO;
        remaining_r <= REM_ZERO;
        busy_r      <= 1'b0;
      end else if (tif.start) begin
        presc_r <= PRESC_ZERO;
        if (tif.duration != REM_ZERO) begin
          state_r     <= ST_RUN;
          remaining_r <= tif.duration;
          busy_r      <= 1'b1;
        end else begin
          state_r     <= ST_IDLE;
          remaining_r <= REM_ZERO;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_RUN, ST_PAUSED: begin
            if (hold_s) begin
              state_r <= ST_PAUSED;
            end else if (expire_s) begin
              state_r     <= ST_IDLE;
              presc_r     <= PRESC_ZERO;
              remaining_r <= REM_ZERO;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              // Leaving PAUSED also advances on this edge, resuming the frozen prescaler.
              state_r <= ST_RUN;
              presc_r <= presc_next_s;
              if (wrap_s) begin
                remaining_r <= rem_dec_s;
              end else begin
                remaining_r <= remaining_r;
              end
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r     <= ST_IDLE;
            presc_r     <= PRESC_ZERO;
            remaining_r <= REM_ZERO;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tif.done      = done_r;
  assign tif.busy      = busy_r;
  assign tif.remaining = remaining_r;

endmodule

// File: tb/tb_phase_timer.sv
// Directed self-checking bench for phase_timer (PRESCALE=1 and PRESCALE=4 instances);
// pause expectations follow whether PHASE_TIMER_PAUSE_EN is defined.
module tb_phase_timer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  phase_timer_if #(.WIDTH(32)) b1 ();
  phase_timer_if #(.WIDTH(16)) b4 ();

  phase_timer #(.WIDTH(32), .PRESCALE(1)) u1 (.clk(clk), .reset(reset), .tif(b1));
  phase_timer #(.WIDTH(16), .PRESCALE(4)) u4 (.clk(clk), .reset(reset), .tif(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic d, input logic b, input logic [31:0] r);
    chk({tag, ".done"}, {31'd0, b1.done}, {31'd0, d});
    chk({tag, ".busy"}, {31'd0, b1.busy}, {31'd0, b});
    chk({tag, ".rem"},  b1.remaining, r);
  endtask

  initial begin
    bit pause_en;
    n_cmp = 0;
    n_err = 0;
`ifdef PHASE_TIMER_PAUSE_EN
    pause_en = 1'b1;
`else
    pause_en = 1'b0;
`endif
    reset = 1'b1;
    b1.start = 1'b0; b1.duration = 32'd0; b1.pause = 1'b0; b1.abort = 1'b0;
    b4.start = 1'b0; b4.duration = 16'd0; b4.pause = 1'b0; b4.abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk1("reset", 1'b0, 1'b0, 32'd0);
    chk("reset.p4_rem", {16'd0, b4.remaining}, 32'd0);

    // Basic countdown of 5
    b1.start = 1'b1; b1.duration = 32'd5;
    tick();
    b1.start = 1'b0;
    chk1("run5.load", 1'b0, 1'b1, 32'd5);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk1("run5.step", 1'b0, 1'b1, 32'(k));
    end
    tick();
    chk1("run5.expire", 1'b1, 1'b0, 32'd0);
    tick();
    chk1("run5.after", 1'b0, 1'b0, 32'd0);

    // Abort at remaining=3
    b1.start = 1'b1; b1.duration = 32'd8;
    tick();
    b1.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk1("abort.pre", 1'b0, 1'b1, 32'd3);
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    chk1("abort.idle", 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("abort.quiet", 1'b0, 1'b0, 32'd0);
    end

    // Restart at remaining=2 with duration=4
    b1.start = 1'b1; b1.duration = 32'd5;
    tick();
    b1.start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk1("restart.pre", 1'b0, 1'b1, 32'd2);
    b1.start = 1'b1; b1.duration = 32'd4;
    tick();
    b1.start = 1'b0;
    chk1("restart.load", 1'b0, 1'b1, 32'd4);
    for (int k = 3; k >= 1; k--) begin
      tick();
      chk1("restart.step", 1'b0, 1'b1, 32'(k));
    end
    tick();
    chk1("restart.expire", 1'b1, 1'b0, 32'd0);

    // Start on the expiry edge: reload wins, no done
    b1.start = 1'b1; b1.duration = 32'd2;
    tick();
    b1.start = 1'b0;
    tick();
    chk1("coinc.pre", 1'b0, 1'b1, 32'd1);
    b1.start = 1'b1; b1.duration = 32'd3;
    tick();
    b1.start = 1'b0;
    chk1("coinc.reload", 1'b0, 1'b1, 32'd3);
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    chk1("coinc.abort", 1'b0, 1'b0, 32'd0);

    // Zero-duration start
    b1.start = 1'b1; b1.duration = 32'd0;
    tick();
    b1.start = 1'b0;
    chk1("zero.done", 1'b1, 1'b0, 32'd0);
    tick();
    chk1("zero.after", 1'b0, 1'b0, 32'd0);

    // Reset mid-phase at remaining=5
    b1.start = 1'b1; b1.duration = 32'd9;
    tick();
    b1.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk1("rstmid.pre", 1'b0, 1'b1, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rstmid.clear", 1'b0, 1'b0, 32'd0);
    tick();
    chk1("rstmid.after", 1'b0, 1'b0, 32'd0);

    // Pause held 7 cycles from remaining=6 (ignored when pause support is off)
    b1.start = 1'b1; b1.duration = 32'd10;
    tick();
    b1.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk1("pause.pre", 1'b0, 1'b1, 32'd6);
    b1.pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (pause_en) chk1("pause.hold", 1'b0, 1'b1, 32'd6);
      else chk1("pause.ignored", (i == 5), (i < 5), (i < 6) ? 32'(5 - i) : 32'd0);
    end
    b1.pause = 1'b0;
    if (pause_en) begin
      for (int k = 5; k >= 1; k--) begin
        tick();
        chk1("pause.resume", 1'b0, 1'b1, 32'(k));
      end
      // Pause on the expiry edge wins; expiry follows the resume
      b1.pause = 1'b1;
      tick();
      chk1("pause.at_expiry", 1'b0, 1'b1, 32'd1);
      b1.pause = 1'b0;
      tick();
      chk1("pause.late_expire", 1'b1, 1'b0, 32'd0);
    end else begin
      tick();
      chk1("pause.idle", 1'b0, 1'b0, 32'd0);
    end
    tick();
    chk1("pause.after", 1'b0, 1'b0, 32'd0);

    // PRESCALE=4, duration=3: decrement every 4th cycle, done 12 cycles after start
    b4.start = 1'b1; b4.duration = 16'd3;
    tick();
    b4.start = 1'b0;
    chk("p4.load", {16'd0, b4.remaining}, 32'd3);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("p4.rem",  {16'd0, b4.remaining}, 32'(3 - e / 4));
      chk("p4.done", {31'd0, b4.done}, {31'd0, (e == 12)});
      chk("p4.busy", {31'd0, b4.busy}, {31'd0, (e < 12)});
    end
    tick();
    chk("p4.after", {31'd0, b4.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
